// File: rtl/jtag_pkg.sv
// jtag_pkg: TAP state encoding, IR capture pattern and default opcode/IDCODE values
package jtag_pkg;
  typedef enum logic [3:0] {
    TLR    = 4'h0,
    RTI    = 4'h1,
    SEL_DR = 4'h2,
    CAP_DR = 4'h3,
    SH_DR  = 4'h4,
    EX1_DR = 4'h5,
    PAU_DR = 4'h6,
    EX2_DR = 4'h7,
    UPD_DR = 4'h8,
    SEL_IR = 4'h9,
    CAP_IR = 4'hA,
    SH_IR  = 4'hB,
    EX1_IR = 4'hC,
    PAU_IR = 4'hD,
    EX2_IR = 4'hE,
    UPD_IR = 4'hF
  } tap_state_e;
  localparam logic [1:0] IR_CAP = 2'b01;
  localparam logic [3:0] OP_IDCODE_DEF = 4'h1;
  localparam logic [3:0] OP_USER_DEF = 4'h8;
  localparam logic [31:0] IDCODE_DEF = 32'h1A2B_3C4D;
endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: JTAG pins (TMS/TDI/TDO/TDO_EN), TAP status and USER DR handshake; master drives, slave is the TAP
interface jtag_tap_ctrl_if #(
  parameter int IR_WIDTH = 4,
  parameter int USER_WIDTH = 8
) ();
  logic TMS;
  logic TDI;
  logic TDO;
  logic TDO_EN;
  logic [3:0] tap_state;
  logic [IR_WIDTH-1:0] ir_out;
  logic user_sel;
  logic [USER_WIDTH-1:0] user_capture_data;
  logic [USER_WIDTH-1:0] user_update_data;
  logic user_update_strb;
  modport master (
    output TMS, TDI, user_capture_data,
    input TDO, TDO_EN, tap_state, ir_out, user_sel, user_update_data, user_update_strb
  );
  modport slave (
    input TMS, TDI, user_capture_data,
    output TDO, TDO_EN, tap_state, ir_out, user_sel, user_update_data, user_update_strb
  );
endinterface

// File: rtl/jtag_tap_state.sv
// jtag_tap_state: 16-state TAP FSM (tck, trst_n, tms in; state plus capture/shift/update decodes and next-is-TLR out)
module jtag_tap_state
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output tap_state_e state,
  output logic       cap_dr,
  output logic       sh_dr,
  output logic       upd_dr,
  output logic       cap_ir,
  output logic       sh_ir,
  output logic       upd_ir,
  output logic       tlr_nxt
);
  tap_state_e state_q, state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:            state_d = tms ? TLR    : RTI;
      RTI:            state_d = tms ? SEL_DR : RTI;
      SEL_DR:         state_d = tms ? SEL_IR : CAP_DR;
      CAP_DR, SH_DR:  state_d = tms ? EX1_DR : SH_DR;
      EX1_DR:         state_d = tms ? UPD_DR : PAU_DR;
      PAU_DR:         state_d = tms ? EX2_DR : PAU_DR;
      EX2_DR:         state_d = tms ? UPD_DR : SH_DR;
      UPD_DR, UPD_IR: state_d = tms ? SEL_DR : RTI;
      SEL_IR:         state_d = tms ? TLR    : CAP_IR;
      CAP_IR, SH_IR:  state_d = tms ? EX1_IR : SH_IR;
      EX1_IR:         state_d = tms ? UPD_IR : PAU_IR;
      PAU_IR:         state_d = tms ? EX2_IR : PAU_IR;
      EX2_IR:         state_d = tms ? UPD_IR : SH_IR;
      default:        state_d = TLR;
    endcase
  end
  always_ff @(posedge tck) state_q <= !trst_n ? TLR : state_d;
  assign state   = state_q;
  assign cap_dr  = state_q == CAP_DR;
  assign sh_dr   = state_q == SH_DR;
  assign upd_dr  = state_q == UPD_DR;
  assign cap_ir  = state_q == CAP_IR;
  assign sh_ir   = state_q == SH_IR;
  assign upd_ir  = state_q == UPD_IR;
  assign tlr_nxt = state_d == TLR;
endmodule

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: TAP controller with IR, BYPASS/IDCODE/USER DRs, TDO mux and USER update strobe (TCK, TRST_N, j: pins/status/handshake)
module jtag_tap_ctrl
  import jtag_pkg::*;
#(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  USER_WIDTH = 8,
  parameter logic [31:0]         IDCODE_VAL = IDCODE_DEF,
  parameter logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(OP_IDCODE_DEF),
  parameter logic [IR_WIDTH-1:0] OP_USER    = IR_WIDTH'(OP_USER_DEF),
  parameter logic [IR_WIDTH-1:0] OP_BYPASS  = '1
) (
  input logic             TCK,
  input logic             TRST_N,
  jtag_tap_ctrl_if.slave  j
);
  tap_state_e st;
  logic cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir, tlr_nxt;
  logic [IR_WIDTH-1:0] ir_q, ir_d, ir_sr_q, ir_sr_d;
  logic byp_q, byp_d, strb_q, strb_d;
  logic [31:0] id_sr_q, id_sr_d;
  logic [USER_WIDTH-1:0] usr_sr_q, usr_sr_d, upd_q, upd_d;
  logic sel_user, sel_id, sel_byp;
  jtag_tap_state u_state (
    .tck     (TCK),
    .trst_n  (TRST_N),
    .tms     (j.TMS),
    .state   (st),
    .cap_dr  (cap_dr),
    .sh_dr   (sh_dr),
    .upd_dr  (upd_dr),
    .cap_ir  (cap_ir),
    .sh_ir   (sh_ir),
    .upd_ir  (upd_ir),
    .tlr_nxt (tlr_nxt)
  );
  assign sel_user = ir_q == OP_USER;
  assign sel_id   = ir_q == OP_IDCODE;
  assign sel_byp  = (ir_q == OP_BYPASS) | !(sel_user | sel_id);
  always_comb begin
    ir_d     = tlr_nxt ? OP_IDCODE : upd_ir ? ir_sr_q : ir_q;
    ir_sr_d  = cap_ir ? IR_WIDTH'(IR_CAP) : sh_ir ? {j.TDI, ir_sr_q[IR_WIDTH-1:1]} : ir_sr_q;
    byp_d    = (sel_byp && cap_dr) ? 1'b0 : (sel_byp && sh_dr) ? j.TDI : byp_q;
    id_sr_d  = (sel_id && cap_dr) ? IDCODE_VAL : (sel_id && sh_dr) ? {j.TDI, id_sr_q[31:1]} : id_sr_q;
    usr_sr_d = (sel_user && cap_dr) ? j.user_capture_data
             : (sel_user && sh_dr) ? ((usr_sr_q >> 1) | (USER_WIDTH'(j.TDI) << (USER_WIDTH - 1)))
             : usr_sr_q;
    strb_d   = sel_user && upd_dr;
    upd_d    = strb_d ? usr_sr_q : upd_q;
  end
  always_ff @(posedge TCK) begin
    if (!TRST_N) begin
      ir_q     <= OP_IDCODE;
      ir_sr_q  <= '0;
      byp_q    <= 1'b0;
      id_sr_q  <= '0;
      usr_sr_q <= '0;
      upd_q    <= '0;
      strb_q   <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      ir_sr_q  <= ir_sr_d;
      byp_q    <= byp_d;
      id_sr_q  <= id_sr_d;
      usr_sr_q <= usr_sr_d;
      upd_q    <= upd_d;
      strb_q   <= strb_d;
    end
  end
  assign j.TDO = sh_ir ? ir_sr_q[0]
               : sh_dr ? (sel_user ? usr_sr_q[0] : sel_id ? id_sr_q[0] : byp_q)
               : 1'b0;
  assign j.TDO_EN           = sh_ir | sh_dr;
  assign j.tap_state        = st;
  assign j.ir_out           = ir_q;
  assign j.user_sel         = sel_user;
  assign j.user_update_data = upd_q;
  assign j.user_update_strb = strb_q;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed JTAG scans with TDO/update scoreboard queues popped by a negedge monitor
module tb_jtag_tap_ctrl;
  logic clk, trst_n;
  int n_tot = 0;
  int n_bad = 0;
  logic tdo_q[$];
  logic [7:0] upd_q[$];
  localparam logic [31:0] IDC = 32'h1A2B_3C4D;
  jtag_tap_ctrl_if #(.IR_WIDTH(4), .USER_WIDTH(8)) bus ();
  jtag_tap_ctrl #(.IR_WIDTH(4), .USER_WIDTH(8)) dut (
    .TCK    (clk),
    .TRST_N (trst_n),
    .j      (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #50000;
    $display("FAIL watchdog expired tot=%0d bad=%0d", n_tot, n_bad);
    $fatal(1);
  end
  always @(negedge clk) begin
    if (bus.TDO_EN === 1'b1) begin
      n_tot++;
      if (tdo_q.size() == 0) begin
        n_bad++;
        $display("FAIL tdo_unexpected got=%b required=none state=%0d", bus.TDO, bus.tap_state);
      end else begin
        logic e;
        e = tdo_q.pop_front();
        if (bus.TDO !== e) begin
          n_bad++;
          $display("FAIL tdo got=%b required=%b state=%0d", bus.TDO, e, bus.tap_state);
        end
      end
    end
    if (bus.user_update_strb === 1'b1) begin
      n_tot++;
      if (upd_q.size() == 0) begin
        n_bad++;
        $display("FAIL strb_unexpected data=%h", bus.user_update_data);
      end else begin
        logic [7:0] e8;
        e8 = upd_q.pop_front();
        if (bus.user_update_data !== e8) begin
          n_bad++;
          $display("FAIL upd_data got=%h required=%h", bus.user_update_data, e8);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h required=%h", name, got, exp);
    end
  endtask
  task automatic step(input logic tms, input logic tdi);
    @(negedge clk);
    #2;
    trst_n = 1'b1;
    bus.TMS = tms;
    bus.TDI = tdi;
    @(posedge clk);
    #1;
  endtask
  task automatic rst_edge();
    @(negedge clk);
    #2;
    trst_n = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic shift_ir(input logic [3:0] din, input logic [3:0] dexp);
    for (int i = 0; i < 4; i++) tdo_q.push_back(dexp[i]);
    step(1, 0);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, din[i]);
    step(1, 0);
    step(0, 0);
  endtask
  task automatic shift_dr(input int n, input logic [31:0] din, input logic [31:0] dexp);
    for (int i = 0; i < n; i++) tdo_q.push_back(dexp[i]);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i]);
    step(1, 0);
    step(0, 0);
  endtask
  initial begin
    logic [7:0] d;
    trst_n = 1'b0;
    bus.TMS = 1'b1;
    bus.TDI = 1'b0;
    bus.user_capture_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.tap_state), 32'h0);
    chk("rst_ir", 32'(bus.ir_out), 32'h1);
    chk("rst_en", 32'(bus.TDO_EN), 32'h0);
    chk("rst_upd", 32'(bus.user_update_data), 32'h0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    tdo_q.push_back(IDC[0]);
    step(0, 0);
    chk("shdr_state", 32'(bus.tap_state), 32'h4);
    rst_edge();
    chk("trst_state", 32'(bus.tap_state), 32'h0);
    chk("trst_ir", 32'(bus.ir_out), 32'h1);
    chk("trst_en", 32'(bus.TDO_EN), 32'h0);
    chk("trst_upd", 32'(bus.user_update_data), 32'h0);
    step(0, 0);
    step(1, 0);
    step(0, 0);
    tdo_q.push_back(IDC[0]);
    step(0, 0);
    repeat (5) step(1, 0);
    chk("tms5_state", 32'(bus.tap_state), 32'h0);
    chk("tms5_ir", 32'(bus.ir_out), 32'h1);
    step(0, 0);
    shift_dr(32, 32'h0, IDC);
    chk("idcode_end_state", 32'(bus.tap_state), 32'h1);
    chk("idcode_end_en", 32'(bus.TDO_EN), 32'h0);
    shift_ir(4'hF, 4'b0001);
    chk("byp_ir", 32'(bus.ir_out), 32'hF);
    chk("byp_sel", 32'(bus.user_sel), 32'h0);
    shift_dr(4, 32'b1101, 32'b1010);
    bus.user_capture_data = 8'hA5;
    shift_ir(4'h8, 4'b0001);
    chk("user_ir", 32'(bus.ir_out), 32'h8);
    chk("user_sel", 32'(bus.user_sel), 32'h1);
    upd_q.push_back(8'h3C);
    shift_dr(8, 32'h3C, 32'hA5);
    chk("user_strb_hi", 32'(bus.user_update_strb), 32'h1);
    chk("user_upd", 32'(bus.user_update_data), 32'h3C);
    step(0, 0);
    chk("user_strb_lo", 32'(bus.user_update_strb), 32'h0);
    bus.user_capture_data = 8'h5A;
    d = 8'h96;
    for (int i = 0; i < 8; i++) tdo_q.push_back(bus.user_capture_data[i]);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    for (int i = 0; i < 4; i++) step(i == 3, d[i]);
    step(0, 1);
    chk("pause_state", 32'(bus.tap_state), 32'h6);
    step(0, 1);
    step(0, 1);
    step(1, 1);
    chk("ex2_state", 32'(bus.tap_state), 32'h7);
    step(0, 1);
    for (int i = 4; i < 8; i++) step(i == 7, d[i]);
    upd_q.push_back(8'h96);
    step(1, 0);
    step(0, 0);
    chk("pause_upd", 32'(bus.user_update_data), 32'h96);
    bus.user_capture_data = 8'hFF;
    for (int i = 0; i < 4; i++) tdo_q.push_back(1'b1);
    step(1, 0);
    step(0, 0);
    step(0, 0);
    repeat (3) step(0, 0);
    rst_edge();
    chk("midrst_strb", 32'(bus.user_update_strb), 32'h0);
    chk("midrst_upd", 32'(bus.user_update_data), 32'h0);
    chk("midrst_ir", 32'(bus.ir_out), 32'h1);
    chk("midrst_state", 32'(bus.tap_state), 32'h0);
    step(0, 0);
    chk("midrst_strb2", 32'(bus.user_update_strb), 32'h0);
    shift_ir(4'h5, 4'b0001);
    chk("unk_ir", 32'(bus.ir_out), 32'h5);
    chk("unk_sel", 32'(bus.user_sel), 32'h0);
    shift_dr(4, 32'b0110, 32'b1100);
    chk("unk_upd", 32'(bus.user_update_data), 32'h0);
    repeat (2) step(0, 0);
    chk("tdo_leftover", 32'(tdo_q.size()), 32'h0);
    chk("upd_leftover", 32'(upd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Full IEEE 1149.1-style TAP controller.
- Contains the 16-state TAP FSM, a parametrised instruction register, and three data registers: BYPASS, IDCODE and a parametrised USER DR.
- Muxes TDO from the selected register and exposes USER DR capture/update handshakes to on-chip debug logic.
- Sits between the chip's JTAG pins and internal test/debug blocks.

Parameters:
- IR_WIDTH, 4, instruction register width (>=2).
- USER_WIDTH, 8, USER data register width (>=1).
- IDCODE_VAL, 32'h1A2B_3C4D, IDCODE DR contents; bit 0 must be 1.
- OP_IDCODE, 4'h1, IDCODE opcode (IR_WIDTH bits).
- OP_USER, 4'h8, USER DR opcode.
- OP_BYPASS, all ones, BYPASS opcode; any unlisted opcode also selects BYPASS.

Ports:
- TCK  in  1  test clock; all flops update on the rising edge.
- TRST_N  in  1  synchronous, active-low reset.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- TDO_EN  out  1  high only in Shift_DR / Shift_IR.
- tap_state  out  4  current state code.
- ir_out  out  IR_WIDTH  active (updated) instruction.
- user_sel  out  1  active instruction == OP_USER.
- user_capture_data  in  USER_WIDTH  value loaded into the USER DR at Capture_DR.
- user_update_data  out  USER_WIDTH  last USER DR value committed at Update_DR.
- user_update_strb  out  1  single-cycle pulse when user_update_data changes.

Behaviour:
- State codes are fixed:
  - TLR=0, RTI=1, SelDR=2, CapDR=3, ShDR=4, Ex1DR=5, PauDR=6, Ex2DR=7, UpdDR=8
  - SelIR=9, CapIR=A, ShIR=B, Ex1IR=C, PauIR=D, Ex2IR=E, UpdIR=F
- Transitions are standard 1149.1 (TMS=1 / TMS=0):
  - TLR: TLR / RTI
  - RTI: SelDR / RTI
  - SelDR: SelIR / CapDR
  - Cap/Shift: Ex1 / Shift
  - Ex1: Upd / Pause
  - Pause: Ex2 / Pause
  - Ex2: Upd / Shift
  - Upd: SelDR / RTI
  - SelIR: TLR / CapIR
- Five consecutive TMS=1 edges reach TLR from any state.
- TRST_N=0 at a rising edge has priority over everything else. It forces:
  - tap_state=TLR, ir_out=OP_IDCODE, IR shift reg=0, bypass=0, USER shift reg=0
  - user_update_data=0, user_update_strb=0
- Any edge that leaves the FSM in TLR (with TRST_N=1) also loads ir_out=OP_IDCODE.
- Register actions happen at the rising edge while tap_state is in the named state; the effect is visible the next cycle:
  - CapIR: IR shift <= {zeros, 2'b01}.
  - ShIR: IR shift <= {TDI, sr[IR_WIDTH-1:1]} (LSB out first).
  - UpdIR: ir_out <= IR shift.
  - CapDR: the selected DR loads. BYPASS loads 0, IDCODE loads IDCODE_VAL, USER loads user_capture_data.
  - ShDR: only the selected DR shifts right with TDI into the MSB. BYPASS is a 1-bit reg.
  - UpdDR with user_sel=1: user_update_data <= USER shift; user_update_strb=1 for exactly the following cycle.
  - UpdDR with any other instruction has no side effect.
- Pause and Exit states hold all shift registers unchanged.
- TDO is combinational:
  - In ShIR: IR shift[0].
  - In ShDR: LSB of the selected DR.
  - Otherwise: 0, with TDO_EN=0.
- ir_out changes only in UpdIR, TLR or on reset, never mid-scan. DR selection for Capture/Shift/Update uses ir_out.
- Reset asserted mid-shift abandons the scan. No update strobe is issued and user_update_data is cleared.

Decomposition:
- Package jtag_pkg holds:
  - the 4-bit state encoding localparams;
  - helper constants for the IR capture pattern (2'b01);
  - the default opcode values.
- Sub-module jtag_tap_state: the TCK/TRST_N/TMS next-state logic plus state register. It outputs tap_state and one-hot decodes of the capture, shift, update and TLR states.
- jtag_tap_ctrl instantiates jtag_tap_state and implements IR, DRs, TDO mux and the user handshake.

Test Plan:
- Reset: TRST_N=0 for 1 edge from state 4 -> tap_state=0, ir_out=4'h1, TDO_EN=0, user_update_data=0. Then TMS=1 x5 from ShDR with TRST_N=1 -> tap_state=0.
- IDCODE read: after reset, TMS 0,1,0,0, then 32 ShDR edges (last with TMS=1) -> TDO sequence LSB-first equals 32'h1A2B_3C4D; TDO_EN=1 only during shift.
- IR capture/BYPASS: SelIR path, shift TDI=1,1,1,1 -> TDO first 4 bits 1,0,0,0; after UpdIR ir_out=4'hF. Then DR shift of TDI 1,0,1,1 -> TDO 0,1,0,1 (one-bit delay).
- USER DR: load OP_USER (4'h8), user_capture_data=8'hA5, shift in 8'h3C -> TDO emits A5 LSB-first; user_update_data=8'h3C; user_update_strb high exactly 1 cycle.
- Pause: in ShDR of USER, go Ex1DR->PauDR for 3 cycles->Ex2DR->ShDR -> shift register unchanged; final update value correct.
- Mid-scan reset: TRST_N=0 during USER ShDR -> no strobe, user_update_data=0, ir_out=4'h1. Unknown opcode 4'h5 -> 1-bit bypass behaviour.
